pipe_control_unit: RTL

Five-stage pipelined successor to the single-cycle control unit.
- Decodes the RV32I subset in the D stage.
- Carries the control bits through ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches and jumps in E.
- Generates the load-use stall, the control-hazard flush and the forwarding selects for the datapath.

---
 rtl/pipe_control_unit_pkg.sv | 92 +++++++++
 rtl/pipe_control_unit_if.sv | 42 ++++
 rtl/pipe_control_unit_hazard.sv | 47 ++++
 rtl/pipe_control_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_control_unit_pkg.sv
// Shared encodings and per-stage control records for the pipelined control unit.
package pipe_ctrl_pkg;

    localparam int RA_W = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101,
        ALU_NOP = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic [3:0] MEM_WR_NONE = 4'b0000;
    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;
    localparam logic [2:0] MEM_RD_BYTE = 3'b000;
    localparam logic [2:0] MEM_RD_NONE = 3'b111;

    // Full control set for one instruction, as held in ID/EX.
    typedef struct packed {
        logic            reg_write;
        logic [3:0]      mem_write;
        logic [2:0]      mem_read;
        logic            mem_src;
        logic            jal;
        logic            jalr;
        logic            beq;
        logic            bne;
        alu_op_e         alu_ctrl;
        logic            alu_src;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } ctrl_t;

    // Subset still needed once the instruction leaves E.
    typedef struct packed {
        logic            reg_write;
        logic [3:0]      mem_write;
        logic [2:0]      mem_read;
        logic            mem_src;
        logic [RA_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_src;
        logic [RA_W-1:0] rd;
    } wb_ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write: 1'b0, mem_write: MEM_WR_NONE, mem_read: MEM_RD_NONE,
        mem_src: 1'b0, jal: 1'b0, jalr: 1'b0, beq: 1'b0, bne: 1'b0,
        alu_ctrl: ALU_NOP, alu_src: 1'b0, rd: '0, rs1: '0, rs2: '0
    };

    localparam mem_ctrl_t MEM_BUBBLE = '{
        reg_write: 1'b0, mem_write: MEM_WR_NONE, mem_read: MEM_RD_NONE,
        mem_src: 1'b0, rd: '0
    };

    localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_src: 1'b0, rd: '0};

    // funct3 (plus funct7[5] for register ops) to ALU operation.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b010:  return ALU_SLT;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// Control unit <-> datapath signal bundle.
interface pipe_control_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]     instr_d;
    logic                      eq_e;
    logic [1:0]                imm_src_d;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic [2:0]                alu_ctrl_e;
    logic                      alu_src_e;
    logic                      pc_src_e;
    logic                      jal_e;
    logic                      jalr_e;
    logic [1:0]                forward_a_e;
    logic [1:0]                forward_b_e;
    logic [3:0]                mem_write_m;
    logic [2:0]                mem_read_m;
    logic                      reg_write_m;
    logic [REG_ADDR_WIDTH-1:0] rd_m;
    logic                      reg_write_w;
    logic                      mem_src_w;
    logic [REG_ADDR_WIDTH-1:0] rd_w;

    modport master (
        input  instr_d, eq_e,
        output imm_src_d, stall_f, stall_d, flush_d, alu_ctrl_e, alu_src_e,
               pc_src_e, jal_e, jalr_e, forward_a_e, forward_b_e,
               mem_write_m, mem_read_m, reg_write_m, rd_m,
               reg_write_w, mem_src_w, rd_w
    );

    modport slave (
        output instr_d, eq_e,
        input  imm_src_d, stall_f, stall_d, flush_d, alu_ctrl_e, alu_src_e,
               pc_src_e, jal_e, jalr_e, forward_a_e, forward_b_e,
               mem_write_m, mem_read_m, reg_write_m, rd_m,
               reg_write_w, mem_src_w, rd_w
    );
endinterface

// File: rtl/pipe_control_unit_hazard.sv
// Load-use stall, control-hazard flush and operand forwarding selects.
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic                      use_rs2_d,
    input  logic                      load_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic                      pc_src_e,
    input  logic                      reg_write_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic                      reg_write_w,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e
);

    // M wins over W so the youngest producer is forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        if (reg_write_m && rd_m != '0 && rd_m == rs)
            return 2'b10;
        else if (reg_write_w && rd_w != '0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    logic load_use;

    // A redirect discards the D instruction anyway, so it overrides the stall.
    always_comb begin
        load_use    = load_e && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (use_rs2_d && (rd_e == rs2_d)));
        flush_d     = pc_src_e;
        stall_f     = load_use && !pc_src_e;
        stall_d     = load_use && !pc_src_e;
        forward_a_e = fwd_sel(rs1_e);
        forward_b_e = fwd_sel(rs2_e);
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Five-stage control: D-stage decode, ID/EX, EX/MEM, MEM/WB control registers.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_control_unit_if.master bus
);

    logic [DATA_WIDTH-1:0] instr;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  unused_instr;
    ctrl_t                 ctrl_d;
    ctrl_t                 ctrl_e;
    mem_ctrl_t             ctrl_m;
    wb_ctrl_t              ctrl_w;
    imm_src_e              imm_src;
    logic                  use_rs2_d;
    logic                  pc_src;
    logic                  bubble_e;

    assign instr        = bus.instr_d;
    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31], instr[29:25]};

    // Decode; anything outside the supported opcodes stays a bubble.
    always_comb begin
        ctrl_d    = CTRL_BUBBLE;
        imm_src   = IMM_I;
        use_rs2_d = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_STORE, OP_REG, OP_BRANCH, OP_JAL, OP_JALR: begin
                ctrl_d.rd  = instr[11:7];
                ctrl_d.rs1 = instr[19:15];
                ctrl_d.rs2 = instr[24:20];
            end
            default: ;
        endcase
        case (opcode)
            OP_LOAD: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_src   = 1'b1;
                ctrl_d.mem_read  = (funct3 == 3'b000) ? MEM_RD_BYTE : MEM_RD_NONE;
            end
            OP_IMM: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(funct3, 1'b0);
                ctrl_d.alu_src   = 1'b1;
            end
            OP_STORE: begin
                ctrl_d.alu_ctrl  = ALU_ADD;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = (funct3 == 3'b010) ? MEM_WR_WORD :
                                   (funct3 == 3'b000) ? MEM_WR_BYTE : MEM_WR_NONE;
                imm_src          = IMM_S;
                use_rs2_d        = 1'b1;
            end
            OP_REG: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(funct3, instr[30]);
                use_rs2_d        = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_d.beq = (funct3 == 3'b000);
                ctrl_d.bne = (funct3 == 3'b001);
                imm_src    = IMM_B;
                use_rs2_d  = 1'b1;
            end
            OP_JAL: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.jal       = 1'b1;
                imm_src          = IMM_J;
            end
            OP_JALR: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.jalr      = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                ctrl_d.alu_src   = 1'b1;
            end
            default: ;
        endcase
    end

    // Redirect decision from the E-stage control and the datapath comparator.
    always_comb begin
        pc_src = (ctrl_e.beq & bus.eq_e) | (ctrl_e.bne & ~bus.eq_e) |
                 ctrl_e.jal | ctrl_e.jalr;
    end

    hazard_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard (
        .rs1_d       (ctrl_d.rs1),
        .rs2_d       (ctrl_d.rs2),
        .use_rs2_d   (use_rs2_d),
        .load_e      (ctrl_e.mem_src),
        .rd_e        (ctrl_e.rd),
        .rs1_e       (ctrl_e.rs1),
        .rs2_e       (ctrl_e.rs2),
        .pc_src_e    (pc_src),
        .reg_write_m (ctrl_m.reg_write),
        .rd_m        (ctrl_m.rd),
        .reg_write_w (ctrl_w.reg_write),
        .rd_w        (ctrl_w.rd),
        .stall_f     (bus.stall_f),
        .stall_d     (bus.stall_d),
        .flush_d     (bus.flush_d),
        .forward_a_e (bus.forward_a_e),
        .forward_b_e (bus.forward_b_e)
    );

    // Both a stall and a flush leave an empty slot in E.
    assign bubble_e = bus.stall_d | bus.flush_d;

    // Stage registers; M and W always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e <= CTRL_BUBBLE;
            ctrl_m <= MEM_BUBBLE;
            ctrl_w <= WB_BUBBLE;
        end else begin
            ctrl_e           <= bubble_e ? CTRL_BUBBLE : ctrl_d;
            ctrl_m.reg_write <= ctrl_e.reg_write;
            ctrl_m.mem_write <= ctrl_e.mem_write;
            ctrl_m.mem_read  <= ctrl_e.mem_read;
            ctrl_m.mem_src   <= ctrl_e.mem_src;
            ctrl_m.rd        <= ctrl_e.rd;
            ctrl_w.reg_write <= ctrl_m.reg_write;
            ctrl_w.mem_src   <= ctrl_m.mem_src;
            ctrl_w.rd        <= ctrl_m.rd;
        end
    end

    assign bus.imm_src_d   = imm_src;
    assign bus.alu_ctrl_e  = ctrl_e.alu_ctrl;
    assign bus.alu_src_e   = ctrl_e.alu_src;
    assign bus.pc_src_e    = pc_src;
    assign bus.jal_e       = ctrl_e.jal;
    assign bus.jalr_e      = ctrl_e.jalr;
    assign bus.mem_write_m = ctrl_m.mem_write;
    assign bus.mem_read_m  = ctrl_m.mem_read;
    assign bus.reg_write_m = ctrl_m.reg_write;
    assign bus.rd_m        = ctrl_m.rd;
    assign bus.reg_write_w = ctrl_w.reg_write;
    assign bus.mem_src_w   = ctrl_w.mem_src;
    assign bus.rd_w        = ctrl_w.rd;

endmodule
